// File: rtl/csa_accum_seq.sv
// csa_accum_seq -- sequential reduction of a stream of unsigned operands.
//
// The running total is kept in carry-save form (S, C). Each accepted beat
// costs one 3:2 compression, so the per-beat path stays short whatever W is.
// The single carry-propagate add happens once per reduction, in RESOLVE.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   clr                 synchronous abort, drops any partial reduction/result
//   in_valid/in_ready   operand beat handshake
//   in_data [W]         operand (unsigned)
//   in_last             final operand of this reduction
//   out_valid/out_ready result handshake
//   out_data [W]        sum modulo 2^W
//   out_count [CW]      number of operands folded into out_data
//   out_ovf             reduction was cut short at MAX_OPS operands

// One bit of the 3:2 compressor: sum and majority (carry-out) of three bits.
module csa_accum_cell (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic maj
);
    assign sum = a ^ b ^ c;
    assign maj = (a & b) | (a & c) | (b & c);
endmodule

module csa_accum_seq #(
    parameter int W       = 64,
    parameter int MAX_OPS = 32,
    parameter int CW      = $clog2(MAX_OPS) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] out_count,
    output logic          out_ovf
);
    typedef enum logic [1:0] {IDLE, ACCUM, RESOLVE, DONE} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  s_q, c_q;
    logic [W-1:0]  sum_b, maj_b;
    logic [W-1:0]  c_csa;
    logic [CW-1:0] count_q, cnt_inc;
    logic          ovf_q;
    logic          accept;
    logic          at_max;

    assign in_ready = (state == IDLE) || (state == ACCUM);
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = count_q + CW'(1);
    assign at_max   = (cnt_inc == CW'(MAX_OPS));

    genvar i;
    generate
        for (i = 0; i < W; i++) begin : g_csa
            csa_accum_cell u_cell (
                .a   (in_data[i]),
                .b   (s_q[i]),
                .c   (c_q[i]),
                .sum (sum_b[i]),
                .maj (maj_b[i])
            );
        end
    endgenerate

    // Carry word weighs twice its bit position; the top carry falls off (mod 2^W).
    assign c_csa = maj_b << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nx = (in_last || MAX_OPS == 1) ? RESOLVE : ACCUM;
                ACCUM:   if (accept && (in_last || at_max)) state_nx = RESOLVE;
                RESOLVE: state_nx = DONE;
                DONE:    if (out_ready) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q       <= '0;
            c_q       <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_ovf   <= 1'b0;
        end else if (clr) begin
            // Overrides any simultaneous beat or result handshake.
            s_q       <= '0;
            c_q       <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    s_q     <= in_data;
                    c_q     <= '0;
                    count_q <= CW'(1);
                    ovf_q   <= !in_last && (MAX_OPS == 1);
                end
                ACCUM: if (accept) begin
                    s_q     <= sum_b;
                    c_q     <= c_csa;
                    count_q <= cnt_inc;
                    // Cut short without in_last: the next beat starts a new reduction.
                    ovf_q   <= !in_last && at_max;
                end
                RESOLVE: begin
                    out_data  <= s_q + c_q;
                    out_count <= count_q;
                    out_ovf   <= ovf_q;
                    out_valid <= 1'b1;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    s_q       <= '0;
                    c_q       <= '0;
                    count_q   <= '0;
                    ovf_q     <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_csa_accum_seq.sv
// Directed bench for csa_accum_seq (W=64, MAX_OPS=32). Inputs change on the
// falling edge; outputs are sampled 1ns after the rising edge.
module tb_csa_accum_seq;
    localparam int W  = 64;
    localparam int MO = 32;
    localparam int CW = $clog2(MO) + 1;

    logic          clk = 1'b0;
    logic          rst_n, clr, in_valid, in_last, out_ready;
    logic          in_ready, out_valid, out_ovf;
    logic [W-1:0]  in_data, out_data;
    logic [CW-1:0] out_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    csa_accum_seq #(.W(W), .MAX_OPS(MO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one beat; returns 1ns after the edge that accepts it.
    task automatic beat(input logic [W-1:0] d, input logic last);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Called 1ns after the last beat's edge with out_ready=1.
    task automatic result(input string tag, input logic [63:0] d, input logic [63:0] n,
                          input logic ovf);
        chk({tag, ".resolve_vld"}, 64'(out_valid), 64'd0);
        chk({tag, ".resolve_rdy"}, 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        chk({tag, ".vld"}, 64'(out_valid), 64'd1);
        chk({tag, ".data"}, out_data, d);
        chk({tag, ".count"}, 64'(out_count), n);
        chk({tag, ".ovf"}, 64'(out_ovf), 64'(ovf));
        @(posedge clk); #1;
        chk({tag, ".idle_vld"}, 64'(out_valid), 64'd0);
        chk({tag, ".idle_rdy"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_data = '0; out_ready = 1'b1;
        #3;
        chk("rst.rdy", 64'(in_ready), 64'd1);
        chk("rst.vld", 64'(out_valid), 64'd0);
        chk("rst.data", out_data, 64'd0);
        chk("rst.count", 64'(out_count), 64'd0);
        chk("rst.ovf", 64'(out_ovf), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel.rdy", 64'(in_ready), 64'd1);

        // 5+7+9
        beat(64'd5, 1'b0); beat(64'd7, 1'b0); beat(64'd9, 1'b1);
        result("sum3", 64'd21, 64'd3, 1'b0);

        // wraparound
        beat(64'hFFFF_FFFF_FFFF_FFFF, 1'b0); beat(64'd2, 1'b1);
        result("wrap", 64'd1, 64'd2, 1'b0);

        // carries out of the top in both words: 2^63 + 2^63 + 3 = 3 mod 2^64
        beat(64'h8000_0000_0000_0000, 1'b0); beat(64'h8000_0000_0000_0000, 1'b0);
        beat(64'd3, 1'b1);
        result("topc", 64'd3, 64'd3, 1'b0);

        // 32 beats without in_last: forced termination, then a lone last beat
        for (int i = 0; i < MO; i++) beat(64'd1, 1'b0);
        result("ovf", 64'd32, 64'd32, 1'b1);
        beat(64'd1, 1'b1);
        result("after_ovf", 64'd1, 64'd1, 1'b0);

        // back-pressure on the result
        out_ready = 1'b0;
        beat(64'h1234, 1'b1);
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("hold.vld", 64'(out_valid), 64'd1);
            chk("hold.data", out_data, 64'h1234);
            chk("hold.count", 64'(out_count), 64'd1);
            chk("hold.rdy", 64'(in_ready), 64'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold.idle_vld", 64'(out_valid), 64'd0);
        chk("hold.idle_rdy", 64'(in_ready), 64'd1);

        // clr coincident with a 4th beat discards everything
        beat(64'd100, 1'b0); beat(64'd200, 1'b0); beat(64'd300, 1'b0);
        @(negedge clk);
        in_valid = 1'b1; in_data = 64'd400; clr = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; clr = 1'b0;
        chk("clr.vld", 64'(out_valid), 64'd0);
        chk("clr.rdy", 64'(in_ready), 64'd1);
        beat(64'd4, 1'b0); beat(64'd6, 1'b1);
        result("post_clr", 64'd10, 64'd2, 1'b0);

        // asynchronous reset between edges while in ACCUM
        beat(64'd1, 1'b0); beat(64'd2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.data", out_data, 64'd0);
        chk("arst.count", 64'(out_count), 64'd0);
        chk("arst.vld", 64'(out_valid), 64'd0);
        chk("arst.rdy", 64'(in_ready), 64'd1);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("arst.no_vld", 64'(out_valid), 64'd0);
        end
        beat(64'd7, 1'b1);
        result("post_rst", 64'd7, 64'd1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
